// File: rtl/vga_fb_read_sched.sv
// Frame-buffer read scheduler: credit-gated fixed-length Avalon-MM burst reads
// walking a linear, double-buffered frame buffer, with sticky FIFO underrun flag.
module vga_fb_read_sched #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned WORDS_PER_FRAME = 76800
) (
  input  logic                         vga_clk,
  input  logic                         vga_reset_n,
  input  logic                         enable,
  input  logic [ADDR_W-1:0]            fb_base_in,
  input  logic                         fb_base_wr,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_read,
  output logic [$clog2(BURST_LEN):0]   avm_burstcount,
  input  logic                         avm_waitrequest,
  input  logic                         vga_rd_valid,
  input  logic                         data_fifo_empty,
  output logic                         frame_start,
  output logic [ADDR_W-1:0]            cur_base,
  output logic                         underrun,
  input  logic                         underrun_clr
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WC_W  = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned BC_W  = $clog2(BURST_LEN) + 1;

  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BURST_LEN * 16);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN * 16 - 1);
  localparam logic [LVL_W-1:0]  LVL_BURST  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W:0]    LVL_LIMIT  = (LVL_W + 1)'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]   WC_BURST   = WC_W'(BURST_LEN);
  localparam logic [WC_W-1:0]   WC_FRAME   = WC_W'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_cur_base;
  logic [ADDR_W-1:0]   r_pend_base;
  logic                r_pend_flag;
  logic [WC_W-1:0]     r_word_cnt;
  logic [LVL_W-1:0]    r_level;
  logic [LVL_W-1:0]    w_level_nxt;
  logic                r_frame_start;
  logic                r_underrun;

  logic                w_start;
  logic                w_accept;
  logic                w_credit;
  logic                w_frame_end;
  logic                w_swap;
  logic [ADDR_W-1:0]   w_next_base;

  assign w_accept    = avm_read & ~avm_waitrequest;
  assign w_credit    = ({1'b0, r_level} + (LVL_W + 1)'(BURST_LEN)) <= LVL_LIMIT;
  assign w_frame_end = (r_word_cnt + WC_BURST) == WC_FRAME;
  // Pending base is adopted both on (re)start from IDLE and at frame wrap.
  assign w_swap      = (w_start | (w_accept & w_frame_end)) & r_pend_flag;
  assign w_next_base = r_pend_flag ? r_pend_base : r_cur_base;

  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) r_state <= IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_state_nxt = CHECK;
      CHECK:   if (!enable) w_state_nxt = IDLE;
               else if (w_credit) w_state_nxt = ISSUE;
      ISSUE:   if (w_accept) w_state_nxt = CHECK;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read = 1'b0;
    w_start  = 1'b0;
    unique case (r_state)
      IDLE:    w_start  = enable;
      ISSUE:   avm_read = 1'b1;
      default: ;
    endcase
  end

  // Pop at zero saturates, but a same-cycle accept is counted first.
  always_comb begin
    w_level_nxt = r_level;
    if (w_accept) w_level_nxt = w_level_nxt + LVL_BURST;
    if (vga_rd_valid && (w_level_nxt != '0)) w_level_nxt = w_level_nxt - LVL_W'(1);
  end

  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      r_addr        <= '0;
      r_cur_base    <= '0;
      r_pend_base   <= '0;
      r_pend_flag   <= 1'b0;
      r_word_cnt    <= '0;
      r_level       <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (fb_base_wr) begin
        r_pend_base <= fb_base_in & ALIGN_MASK;
        r_pend_flag <= 1'b1;
      end else if (w_swap) begin
        r_pend_flag <= 1'b0;
      end

      if (w_swap) r_cur_base <= r_pend_base;

      if (w_start) begin
        r_addr     <= w_next_base;
        r_word_cnt <= '0;
      end else if (w_accept) begin
        if (w_frame_end) begin
          r_addr     <= w_next_base;
          r_word_cnt <= '0;
        end else begin
          r_addr     <= r_addr + STRIDE;
          r_word_cnt <= r_word_cnt + WC_BURST;
        end
      end

      r_level       <= w_level_nxt;
      r_frame_start <= w_accept & (r_word_cnt == '0);

      if (vga_rd_valid && data_fifo_empty) r_underrun <= 1'b1;
      else if (underrun_clr)               r_underrun <= 1'b0;
    end
  end

  assign avm_address    = r_addr;
  assign avm_burstcount = BC_W'(BURST_LEN);
  assign frame_start    = r_frame_start;
  assign cur_base       = r_cur_base;
  assign underrun       = r_underrun;

endmodule

// File: tb/tb_vga_fb_read_sched.sv
// Directed bench for vga_fb_read_sched; frame length shortened to 1024 words
// (64 bursts) so the frame-wrap scenario runs in a few thousand cycles.
module tb_vga_fb_read_sched;

  localparam int unsigned TB_WPF = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] fb_base_in = '0;
  logic        fb_base_wr = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;
  logic        vga_rd_valid = 1'b0;
  logic        data_fifo_empty = 1'b0;
  logic        frame_start;
  logic [31:0] cur_base;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  vga_fb_read_sched #(
    .ADDR_W(32), .BURST_LEN(16), .FIFO_DEPTH(256), .WORDS_PER_FRAME(TB_WPF)
  ) dut (
    .vga_clk(clk), .vga_reset_n(rst_n), .enable(enable),
    .fb_base_in(fb_base_in), .fb_base_wr(fb_base_wr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .vga_rd_valid(vga_rd_valid),
    .data_fifo_empty(data_fifo_empty), .frame_start(frame_start),
    .cur_base(cur_base), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] acc_addr[$];
  int acc_cnt = 0;
  int fs_cnt  = 0;
  int fs_at   = 0;

  // Inputs change 1 time unit after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt = fs_cnt + 1;
      fs_at  = acc_cnt;
    end
    if (avm_read && !avm_waitrequest) begin
      acc_addr.push_back(avm_address);
      acc_cnt = acc_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (avm_read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic write_base(input logic [31:0] b);
    fb_base_in = b;
    fb_base_wr = 1'b1;
    tick();
    fb_base_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ticks(2);
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %0b want 0", avm_read); end
    n_cmp++; if (avm_address !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", avm_address); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %0b want 0", frame_start); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
    n_cmp++; if (cur_base !== 32'h0) begin n_bad++; $display("FAIL reset_cur_base: got %h want 0", cur_base); end
    n_cmp++; if (avm_burstcount !== 5'd16) begin n_bad++; $display("FAIL burstcount: got %0d want 16", avm_burstcount); end
    n_cmp++; if (dut.r_level !== 9'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", dut.r_level); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int base, f0, bad_i;
    write_base(32'h2000_0047);
    tick();
    base = acc_cnt;
    f0   = fs_cnt;
    enable = 1'b1;
    ticks(100);
    n_cmp++; if (acc_cnt - base !== 16) begin n_bad++; $display("FAIL fill_count: got %0d want 16", acc_cnt - base); end
    bad_i = -1;
    for (int i = 0; i < 16; i++)
      if (base + i >= acc_addr.size() || acc_addr[base + i] !== 32'h2000_0000 + 32'(i * 256)) begin
        if (bad_i < 0) bad_i = i;
      end
    n_cmp++; if (bad_i >= 0) begin n_bad++; $display("FAIL fill_addr: burst %0d wrong, want %h", bad_i, 32'h2000_0000 + 32'(bad_i * 256)); end
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL fill_idle_read: got %0b want 0", avm_read); end
    n_cmp++; if (dut.r_level !== 9'd256) begin n_bad++; $display("FAIL fill_level: got %0d want 256", dut.r_level); end
    n_cmp++; if (fs_cnt - f0 !== 1 || fs_at !== base + 1) begin n_bad++; $display("FAIL fill_frame_start: pulses %0d at %0d want 1 at %0d", fs_cnt - f0, fs_at, base + 1); end
    n_cmp++; if (cur_base !== 32'h2000_0000) begin n_bad++; $display("FAIL fill_cur_base: got %h want 20000000", cur_base); end
  endtask

  task automatic test_credit();
    int base;
    base = acc_cnt;
    vga_rd_valid = 1'b1;
    ticks(15);
    vga_rd_valid = 1'b0;
    ticks(10);
    n_cmp++; if (acc_cnt !== base) begin n_bad++; $display("FAIL credit_15_no_cmd: got %0d cmds want 0", acc_cnt - base); end
    n_cmp++; if (dut.r_level !== 9'd241) begin n_bad++; $display("FAIL credit_level_241: got %0d want 241", dut.r_level); end
    vga_rd_valid = 1'b1;
    tick();
    vga_rd_valid = 1'b0;
    ticks(10);
    n_cmp++; if (acc_cnt - base !== 1) begin n_bad++; $display("FAIL credit_16_one_cmd: got %0d cmds want 1", acc_cnt - base); end
    n_cmp++; if (acc_addr[acc_addr.size() - 1] !== 32'h2000_1000) begin n_bad++; $display("FAIL credit_addr: got %h want 20001000", acc_addr[acc_addr.size() - 1]); end
    n_cmp++; if (dut.r_level !== 9'd256) begin n_bad++; $display("FAIL credit_level_256: got %0d want 256", dut.r_level); end
  endtask

  task automatic test_waitreq();
    int base;
    bit ok, stable;
    logic [31:0] a0;
    base = acc_cnt;
    avm_waitrequest = 1'b1;
    vga_rd_valid = 1'b1;
    ticks(16);
    vga_rd_valid = 1'b0;
    wait_read(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wait_raise: avm_read %0b want 1 within bound", avm_read); end
    a0 = avm_address;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (avm_read !== 1'b1 || avm_address !== a0) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL wait_stable: read %0b addr %h want 1 %h", avm_read, avm_address, a0); end
    n_cmp++; if (a0 !== 32'h2000_1100) begin n_bad++; $display("FAIL wait_addr: got %h want 20001100", a0); end
    n_cmp++; if (acc_cnt !== base) begin n_bad++; $display("FAIL wait_no_accept: got %0d want 0", acc_cnt - base); end
    avm_waitrequest = 1'b0;
    ticks(5);
    n_cmp++; if (acc_cnt - base !== 1) begin n_bad++; $display("FAIL wait_one_accept: got %0d want 1", acc_cnt - base); end
    n_cmp++; if (dut.r_level !== 9'd256) begin n_bad++; $display("FAIL wait_level: got %0d want 256", dut.r_level); end
  endtask

  task automatic test_frame();
    int base, f0, bad_i;
    bit wrote;
    enable = 1'b0;
    ticks(5);
    base = acc_cnt;
    f0   = fs_cnt;
    wrote = 1'b0;
    vga_rd_valid = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 4000 && (acc_cnt - base) < 65; c++) begin
      tick();
      if (!wrote && (acc_cnt - base) >= 32) begin
        write_base(32'h3000_0000);
        wrote = 1'b1;
      end
    end
    enable = 1'b0;
    vga_rd_valid = 1'b0;
    ticks(3);
    n_cmp++; if (acc_cnt - base < 65) begin n_bad++; $display("FAIL frame_timeout: got %0d bursts want 65", acc_cnt - base); end
    else begin
      bad_i = -1;
      for (int i = 0; i < 64; i++)
        if (acc_addr[base + i] !== 32'h2000_0000 + 32'(i * 256) && bad_i < 0) bad_i = i;
      n_cmp++; if (bad_i >= 0) begin n_bad++; $display("FAIL frame_addr: burst %0d got %h want %h", bad_i, acc_addr[base + bad_i], 32'h2000_0000 + 32'(bad_i * 256)); end
      n_cmp++; if (acc_addr[base + 63] !== 32'h2000_3F00) begin n_bad++; $display("FAIL frame_last: got %h want 20003f00", acc_addr[base + 63]); end
      n_cmp++; if (acc_addr[base + 64] !== 32'h3000_0000) begin n_bad++; $display("FAIL frame_wrap: got %h want 30000000", acc_addr[base + 64]); end
    end
    n_cmp++; if (fs_cnt - f0 !== 2 || fs_at !== base + 65) begin n_bad++; $display("FAIL frame_start_wrap: pulses %0d at %0d want 2 at %0d", fs_cnt - f0, fs_at, base + 65); end
    n_cmp++; if (cur_base !== 32'h3000_0000) begin n_bad++; $display("FAIL frame_cur_base: got %h want 30000000", cur_base); end
    n_cmp++; if (dut.r_pend_flag !== 1'b0) begin n_bad++; $display("FAIL frame_pend_clear: got %0b want 0", dut.r_pend_flag); end
  endtask

  task automatic test_underrun();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vga_rd_valid = 1'b1;
    data_fifo_empty = 1'b1;
    tick();
    vga_rd_valid = 1'b0;
    data_fifo_empty = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set: got %0b want 1", underrun); end
    n_cmp++; if (dut.r_level !== 9'd0) begin n_bad++; $display("FAIL underrun_level_sat: got %0d want 0", dut.r_level); end
    ticks(3);
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_sticky: got %0b want 1", underrun); end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clr: got %0b want 0", underrun); end
    vga_rd_valid = 1'b1;
    data_fifo_empty = 1'b1;
    underrun_clr = 1'b1;
    tick();
    vga_rd_valid = 1'b0;
    data_fifo_empty = 1'b0;
    underrun_clr = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set_wins: got %0b want 1", underrun); end
  endtask

  task automatic test_enable_abort();
    int base;
    bit ok;
    write_base(32'h4000_0000);
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    wait_read(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_raise: avm_read %0b want 1 within bound", avm_read); end
    base = acc_cnt;
    enable = 1'b0;
    ticks(3);
    n_cmp++; if (avm_read !== 1'b1 || avm_address !== 32'h4000_0000) begin n_bad++; $display("FAIL abort_hold: read %0b addr %h want 1 40000000", avm_read, avm_address); end
    avm_waitrequest = 1'b0;
    ticks(5);
    n_cmp++; if (acc_cnt - base !== 1) begin n_bad++; $display("FAIL abort_complete: got %0d accepts want 1", acc_cnt - base); end
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL abort_idle_read: got %0b want 0", avm_read); end
    // Re-enabling restarts the frame at cur_base only if the FSM went back to IDLE.
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    wait_read(ok);
    n_cmp++; if (!ok || avm_address !== 32'h4000_0000) begin n_bad++; $display("FAIL abort_restart_addr: got %h want 40000000", avm_address); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL async_rst_read: got %0b want 0", avm_read); end
    n_cmp++; if (avm_address !== 32'h0 || cur_base !== 32'h0) begin n_bad++; $display("FAIL async_rst_addr: addr %h base %h want 0 0", avm_address, cur_base); end
    n_cmp++; if (frame_start !== 1'b0 || underrun !== 1'b0 || dut.r_level !== 9'd0) begin n_bad++; $display("FAIL async_rst_misc: fs %0b ur %0b level %0d want 0 0 0", frame_start, underrun, dut.r_level); end
    enable = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_credit();
    test_waitreq();
    test_frame();
    test_underrun();
    test_enable_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
